// File: rtl/icache_param.sv
// Direct-mapped instruction cache with configurable sets and words per line, refilled one word
// at a time from the memory arbiter. Define ICACHE_PERF_EN to add hit/miss counters.
module icache_param #(
    parameter int SETS        = 16,
    parameter int BLOCK_WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        flush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int OB  = $clog2(BLOCK_WORDS);
    localparam int IB  = $clog2(SETS);
    localparam int TB  = 30 - OB - IB;
    localparam int WCW = (OB == 0) ? 1 : OB;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(BLOCK_WORDS - 1);

    typedef enum logic {LOOKUP, REFILL} state_t;

    state_t          state_q, state_d;
    logic [SETS-1:0] valid_q, valid_d;
    logic [TB-1:0]   mtag_q,  mtag_d;
    logic [IB-1:0]   midx_q,  midx_d;
    logic [WCW-1:0]  wcnt_q,  wcnt_d;

    // Tag and data arrays are never reset; valid_q alone decides whether a line may hit.
    logic [TB-1:0] tag_mem  [SETS];
    logic [31:0]   data_mem [SETS][BLOCK_WORDS];

    logic [TB-1:0]  req_tag;
    logic [IB-1:0]  req_idx;
    logic [WCW-1:0] req_off;
    logic           unused_byte_bits;

    assign req_tag          = imemaddr[31 -: TB];
    assign req_idx          = imemaddr[OB+2 +: IB];
    assign unused_byte_bits = ^imemaddr[1:0];

    generate
        if (OB == 0) begin : g_no_off
            logic unused_off_bit;
            assign unused_off_bit = imemaddr[2];
            assign req_off        = '0;
        end else begin : g_off
            assign req_off = imemaddr[2 +: WCW];
        end
    endgenerate

    logic lookup_hit;
    logic miss_start;
    logic fill_go;
    logic fill_last;

    assign lookup_hit = (state_q == LOOKUP) && imemREN && valid_q[req_idx]
                        && (tag_mem[req_idx] == req_tag);
    assign miss_start = (state_q == LOOKUP) && imemREN && !lookup_hit && !flush;
    assign fill_go    = (state_q == REFILL) && !iwait && !flush && !RST;
    assign fill_last  = fill_go && (wcnt_q == LAST_WORD);

    // Outputs are combinational so a hit returns its word in the request cycle.
    logic [31:0] refill_addr;
    assign refill_addr = (32'({mtag_q, midx_q}) << (OB + 2)) | (32'(wcnt_q) << 2);

    assign ihit     = !RST && !flush && lookup_hit;
    assign imemload = ihit ? data_mem[req_idx][req_off] : 32'h0;
    assign iREN     = !RST && !flush && (state_q == REFILL);
    assign iaddr    = (!RST && (state_q == REFILL)) ? refill_addr : 32'h0;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        mtag_d  = mtag_q;
        midx_d  = midx_q;
        wcnt_d  = wcnt_q;
        if (flush) begin
            valid_d = '0;
            state_d = LOOKUP;
            wcnt_d  = '0;
        end else if (state_q == LOOKUP) begin
            if (miss_start) begin
                mtag_d           = req_tag;
                midx_d           = req_idx;
                wcnt_d           = '0;
                valid_d[req_idx] = 1'b0;
                state_d          = REFILL;
            end
        end else begin
            if (!iwait) begin
                if (wcnt_q == LAST_WORD) begin
                    wcnt_d          = '0;
                    valid_d[midx_q] = 1'b1;
                    state_d         = LOOKUP;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= LOOKUP;
            valid_q <= '0;
            mtag_q  <= '0;
            midx_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            mtag_q  <= mtag_d;
            midx_q  <= midx_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_go) begin
            data_mem[midx_q][wcnt_q] <= iload;
        end
        if (fill_last) begin
            tag_mem[midx_q] <= mtag_q;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (ihit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_start) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_param.sv
// Randomised bench for icache_param: a block-address cache model predicts every output each
// cycle, and directed scenarios pin literal values for reset, fills, conflicts, stalls and flush.
module tb_icache_param;
    localparam int SETS = 16;
    localparam int BW   = 2;
    localparam int OB   = $clog2(BW);

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        flush = 1'b0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b0;
    logic [31:0] iload = 32'h0;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_param #(.SETS(SETS), .BLOCK_WORDS(BW)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload)
`ifdef ICACHE_PERF_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: each set remembers which block address it holds; a pending miss is a queue of
    // word addresses still to be fetched from memory.
    bit          m_valid [SETS];
    logic [31:0] m_blk   [SETS];
    bit          m_busy = 0;
    bit          m_init = 0;
    int          m_pidx;
    logic [31:0] m_pblk;
    logic [31:0] m_q[$];
    logic [31:0] m_hits = 0;
    logic [31:0] m_misses = 0;

    logic [31:0] c_blk;
    int          c_idx;
    bit          c_hit;
    bit          c_ren;

    always @(negedge CLK) begin
        c_blk = imemaddr >> (OB + 2);
        c_idx = int'(c_blk % SETS);
        c_hit = !RST && m_init && !m_busy && !flush && imemREN && m_valid[c_idx]
                && (m_blk[c_idx] == c_blk);
        c_ren = !RST && m_busy && !flush;
        check("ihit", {31'b0, ihit}, {31'b0, c_hit});
        check("imemload", imemload, c_hit ? memf(imemaddr & ~32'h3) : 32'h0);
        check("iREN", {31'b0, iREN}, {31'b0, c_ren});
        if (c_ren) check("iaddr", iaddr, m_q[0]);
        if (RST) check("iaddr_rst", iaddr, 32'h0);
`ifdef ICACHE_PERF_EN
        if (m_init) begin
            check("hit_cnt", hit_cnt, m_hits);
            check("miss_cnt", miss_cnt, m_misses);
        end
`endif
        iload = (m_busy && m_q.size() > 0) ? memf(m_q[0]) : $urandom;
        if (c_hit) m_hits++;
        if (RST) begin
            for (int s = 0; s < SETS; s++) m_valid[s] = 0;
            m_busy = 0; m_q.delete(); m_hits = 0; m_misses = 0; m_init = 1;
        end else if (m_init) begin
            if (flush) begin
                for (int s = 0; s < SETS; s++) m_valid[s] = 0;
                m_busy = 0; m_q.delete();
            end else if (m_busy) begin
                if (!iwait) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_valid[m_pidx] = 1; m_blk[m_pidx] = m_pblk; m_busy = 0;
                    end
                end
            end else if (imemREN && !c_hit) begin
                m_busy = 1; m_pidx = c_idx; m_pblk = c_blk; m_valid[c_idx] = 0; m_misses++;
                for (int w = 0; w < BW; w++) m_q.push_back((c_blk << (OB + 2)) + 32'(w * 4));
            end
        end
    end

    task automatic drive(input logic r, input logic ren, input logic fl, input logic wt,
                         input logic [31:0] a);
        @(posedge CLK); #1;
        RST = r; imemREN = ren; flush = fl; iwait = wt; imemaddr = a;
        @(negedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 15)) << 3)
          | (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
        return a;
    endfunction

    initial begin
        // Reset, then a cold miss at 0x0 requests memory the following cycle.
        drive(1, 1, 0, 0, 32'h0);
        drive(1, 1, 0, 0, 32'h0);
        check("rst_ihit", {31'b0, ihit}, 32'h0);
        drive(0, 1, 0, 0, 32'h0);
        check("cold_ihit0", {31'b0, ihit}, 32'h0);
        drive(0, 1, 0, 0, 32'h0);
        check("cold_iren", {31'b0, iREN}, 32'h1);
        check("cold_iaddr", iaddr, 32'h0);
        drive(0, 1, 0, 0, 32'h0);

        // Two-word fill of 0x100, then both words hit with no memory traffic.
        drive(0, 1, 0, 0, 32'h100);
        check("m100_ihit", {31'b0, ihit}, 32'h0);
        drive(0, 1, 0, 0, 32'h100);
        check("m100_w0", iaddr, 32'h100);
        drive(0, 1, 0, 0, 32'h100);
        check("m100_w1", iaddr, 32'h104);
        drive(0, 1, 0, 0, 32'h100);
        check("h100_ihit", {31'b0, ihit}, 32'h1);
        check("h100_data", imemload, 32'hDEAD0100);
        drive(0, 1, 0, 0, 32'h104);
        check("h104_ihit", {31'b0, ihit}, 32'h1);
        check("h104_data", imemload, 32'hDEAD0104);
        check("h104_iren", {31'b0, iREN}, 32'h0);

        // Conflict: 0x180 evicts 0x100 from set 0.
        drive(0, 1, 0, 0, 32'h180);
        check("c180_miss", {31'b0, ihit}, 32'h0);
        drive(0, 1, 0, 0, 32'h180);
        check("c180_w0", iaddr, 32'h180);
        drive(0, 1, 0, 0, 32'h180);
        check("c180_w1", iaddr, 32'h184);
        drive(0, 1, 0, 0, 32'h180);
        check("c180_hit", imemload, 32'hDEAD0180);
        drive(0, 1, 0, 0, 32'h100);
        check("c100_remiss", {31'b0, ihit}, 32'h0);
        drive(0, 1, 0, 0, 32'h100);
        drive(0, 1, 0, 0, 32'h100);
        drive(0, 1, 0, 0, 32'h100);
        check("c100_rehit", {31'b0, ihit}, 32'h1);

        // Flush after the first refill word aborts the refill and empties the cache.
        drive(0, 1, 0, 0, 32'h180);
        drive(0, 1, 0, 0, 32'h180);
        check("f180_w0", iaddr, 32'h180);
        drive(0, 1, 1, 0, 32'h180);
        check("flush_iren", {31'b0, iREN}, 32'h0);
        drive(0, 1, 0, 0, 32'h100);
        check("postflush_iren", {31'b0, iREN}, 32'h0);
        check("postflush_miss", {31'b0, ihit}, 32'h0);
        drive(0, 1, 0, 0, 32'h100);
        drive(0, 1, 0, 0, 32'h100);

        // Stalled refill of 0x200 while the fetch address wanders to 0x300.
        drive(0, 1, 0, 0, 32'h200);
        for (int w = 0; w < BW; w++) begin
            for (int k = 0; k < 3; k++) begin
                drive(0, 1, 0, 1, 32'h300);
                check("stall_iaddr", iaddr, 32'h200 + 32'(w * 4));
                check("stall_ihit", {31'b0, ihit}, 32'h0);
            end
            drive(0, 1, 0, 0, 32'h300);
            check("stall_last", iaddr, 32'h200 + 32'(w * 4));
        end
        drive(0, 1, 0, 0, 32'h204);
        check("stall_fill_hit", {31'b0, ihit}, 32'h1);
        check("stall_fill_data", imemload, 32'hDEAD0204);

        // Randomised traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            @(posedge CLK); #1;
            RST     = ($urandom_range(0, 199) == 0);
            flush   = ($urandom_range(0, 39) == 0);
            imemREN = ($urandom_range(0, 9) != 0);
            iwait   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) imemaddr = rand_addr();
        end
        drive(0, 0, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
